// File: rtl/wb_select_buf.sv
// Write-back source select feeding a 2-entry in-order buffer toward the register file.
// Optional `WB_SELECT_FWD_EN adds a forwarding lookup over the held entries.
module wb_select_buf #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_loadi,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        shift_ctrl,
    input  logic [WIDTH-1:0]  shift_out,
    input  logic              jump,
    input  logic [WIDTH-1:0]  pc_link,
    input  logic              copy_reg,
    input  logic [WIDTH-1:0]  reg1_data,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [ADDR_W-1:0] dest,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data,
    output logic [1:0]        occupancy
`ifdef WB_SELECT_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [WIDTH-1:0]  fwd_data
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  sel_data;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [WIDTH-1:0]  data0, data1;
    logic              push, pop;

    always_comb begin
        if (is_loadi)
            sel_data = WIDTH'(imm);
        else if (shift_ctrl != 2'b00)
            sel_data = shift_out;
        else if (jump)
            sel_data = pc_link;
        else if (copy_reg)
            sel_data = reg1_data;
        else
            sel_data = alu_result;
    end

    // Outputs decode only registered state, so there is no input-to-output path.
    assign in_ready  = (state != FULL);
    assign wb_valid  = (state != EMPTY);
    assign wb_addr   = addr0;
    assign wb_data   = data0;
    assign occupancy = state;

    assign push = in_valid && in_ready;
    assign pop  = wb_valid && wb_ready;

    // Slot 0 is always the head; slot 1 holds the younger entry when FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            addr0 <= '0;
            data0 <= '0;
            addr1 <= '0;
            data1 <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        addr0 <= dest;
                        data0 <= sel_data;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        addr0 <= dest;
                        data0 <= sel_data;
                    end else if (push) begin
                        addr1 <= dest;
                        data1 <= sel_data;
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        addr0 <= addr1;
                        data0 <= data1;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef WB_SELECT_FWD_EN
    // Youngest match wins: check slot 1 before the head.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (state == FULL && addr1 == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = data1;
        end else if (state != EMPTY && addr0 == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = data0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_select_buf.sv
// Bench for wb_select_buf: select-priority vector table, buffer corner sequences,
// and a randomized run against a queue-based reference model.
module tb_wb_select_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, is_loadi, jump, copy_reg;
    logic [3:0]  imm, dest, wb_addr;
    logic [1:0]  shift_ctrl, occupancy;
    logic [15:0] shift_out, pc_link, reg1_data, alu_result, wb_data;
    logic        wb_valid, wb_ready;
`ifdef WB_SELECT_FWD_EN
    logic [3:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    wb_select_buf dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .is_loadi(is_loadi), .imm(imm), .shift_ctrl(shift_ctrl), .shift_out(shift_out),
        .jump(jump), .pc_link(pc_link), .copy_reg(copy_reg), .reg1_data(reg1_data),
        .alu_result(alu_result), .dest(dest), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .occupancy(occupancy)
`ifdef WB_SELECT_FWD_EN
        , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sel();
        is_loadi = 0; imm = 0; shift_ctrl = 0; jump = 0; copy_reg = 0;
    endtask

    task automatic push_alu(input logic [15:0] v, input logic [3:0] d, input logic rdy);
        clear_sel();
        in_valid = 1; alu_result = v; dest = d; wb_ready = rdy;
        tick();
        in_valid = 0;
    endtask

    // Reference selection written straight from the priority rule.
    function automatic logic [15:0] ref_sel(input logic li, input logic [3:0] im,
        input logic [1:0] sc, input logic [15:0] so, input logic jp, input logic [15:0] pl,
        input logic cr, input logic [15:0] r1, input logic [15:0] al);
        if (li) return {12'h000, im};
        if (sc != 0) return so;
        if (jp) return pl;
        if (cr) return r1;
        return al;
    endfunction

    typedef struct {
        logic        li;
        logic [3:0]  im;
        logic [1:0]  sc;
        logic        jp;
        logic        cr;
        logic [3:0]  d;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];
    logic [19:0] model_q[$];

    initial begin
        vecs[0] = '{1'b1, 4'hA, 2'b01, 1'b0, 1'b0, 4'd1,  16'h000A};
        vecs[1] = '{1'b0, 4'h0, 2'b00, 1'b1, 1'b1, 4'd3,  16'h0042};
        vecs[2] = '{1'b0, 4'h3, 2'b10, 1'b1, 1'b0, 4'd7,  16'h5151};
        vecs[3] = '{1'b0, 4'h0, 2'b11, 1'b0, 1'b1, 4'd4,  16'h5151};
        vecs[4] = '{1'b0, 4'h0, 2'b00, 1'b0, 1'b1, 4'd2,  16'h7E7E};
        vecs[5] = '{1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 4'd15, 16'hA1A1};
        vecs[6] = '{1'b1, 4'hF, 2'b11, 1'b1, 1'b1, 4'd0,  16'h000F};
        vecs[7] = '{1'b0, 4'h0, 2'b00, 1'b1, 1'b0, 4'd9,  16'h0042};

        rst_n = 0; in_valid = 0; wb_ready = 0; dest = 0; clear_sel();
        shift_out = 16'h5151; pc_link = 16'h0042; reg1_data = 16'h7E7E; alu_result = 16'hA1A1;
`ifdef WB_SELECT_FWD_EN
        fwd_addr = 0;
`endif
        #12;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_addr", wb_addr, 0);
        @(negedge clk); rst_n = 1;
        tick();
        check("rst_in_ready", in_ready, 1);

        // Priority table: push from EMPTY, expect one-cycle latency, then drain.
        for (int i = 0; i < 8; i++) begin
            is_loadi = vecs[i].li; imm = vecs[i].im; shift_ctrl = vecs[i].sc;
            jump = vecs[i].jp; copy_reg = vecs[i].cr; dest = vecs[i].d;
            in_valid = 1; wb_ready = 1;
            #1;
            check($sformatf("vec%0d_no_comb", i), wb_valid, 0);
            tick();
            in_valid = 0;
            check($sformatf("vec%0d_valid", i), wb_valid, 1);
            check($sformatf("vec%0d_data", i), wb_data, vecs[i].exp);
            check($sformatf("vec%0d_addr", i), wb_addr, vecs[i].d);
            tick();
            check($sformatf("vec%0d_drained", i), occupancy, 0);
        end

        // Fill to FULL, third push ignored, drain in order.
        push_alu(16'h1111, 4'd1, 0);
        push_alu(16'h2222, 4'd2, 0);
        check("full_occ", occupancy, 2);
        check("full_in_ready", in_ready, 0);
        push_alu(16'h3333, 4'd3, 0);
        check("full_ignored_occ", occupancy, 2);
        check("full_hold_data", wb_data, 16'h1111);
        check("full_hold_addr", wb_addr, 1);
        wb_ready = 1;
        tick();
        check("drain1_data", wb_data, 16'h2222);
        check("drain1_occ", occupancy, 1);
        tick();
        check("drain2_occ", occupancy, 0);
        check("drain2_valid", wb_valid, 0);

        // Simultaneous push and pop in ONE.
        push_alu(16'h4444, 4'd4, 0);
        push_alu(16'h3333, 4'd5, 1);
        check("pushpop_occ", occupancy, 1);
        check("pushpop_data", wb_data, 16'h3333);
        check("pushpop_addr", wb_addr, 5);
        wb_ready = 1;
        tick();

`ifdef WB_SELECT_FWD_EN
        push_alu(16'h00AA, 4'd5, 0);
        push_alu(16'h00BB, 4'd5, 0);
        fwd_addr = 5; #1;
        check("fwd_hit5", fwd_hit, 1);
        check("fwd_data5", fwd_data, 16'h00BB);
        fwd_addr = 6; #1;
        check("fwd_hit6", fwd_hit, 0);
        check("fwd_data6", fwd_data, 0);
        wb_ready = 1;
        tick(); tick();
`endif

        // Asynchronous reset while FULL.
        push_alu(16'h5555, 4'd6, 0);
        push_alu(16'h6666, 4'd7, 0);
        check("prerst_occ", occupancy, 2);
        #2 rst_n = 0;
        #1;
        check("midrst_valid", wb_valid, 0);
        check("midrst_occ", occupancy, 0);
        check("midrst_data", wb_data, 0);
        @(negedge clk); rst_n = 1; wb_ready = 1; in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("postrst_valid%0d", i), wb_valid, 0);
        end

        // Randomized run against the queue model.
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic [15:0] exp_d;
            logic        m_push, m_pop;
            in_valid = $urandom_range(0, 1); wb_ready = $urandom_range(0, 1);
            is_loadi = ($urandom_range(0, 5) == 0); imm = 4'($urandom);
            shift_ctrl = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            jump = $urandom_range(0, 1); copy_reg = $urandom_range(0, 1);
            shift_out = 16'($urandom); pc_link = 16'($urandom);
            reg1_data = 16'($urandom); alu_result = 16'($urandom); dest = 4'($urandom);
            #1;
            check("rnd_occ", occupancy, model_q.size());
            check("rnd_in_ready", in_ready, model_q.size() < 2);
            check("rnd_valid", wb_valid, model_q.size() > 0);
            if (model_q.size() > 0)
                check("rnd_head", {wb_addr, wb_data}, model_q[0]);
            exp_d  = ref_sel(is_loadi, imm, shift_ctrl, shift_out, jump, pc_link,
                             copy_reg, reg1_data, alu_result);
            m_push = in_valid && (model_q.size() < 2);
            m_pop  = wb_ready && (model_q.size() > 0);
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back({dest, exp_d});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
